// File: rtl/mem_access_unit_if.sv
// Request/acknowledge memory bus between the MIPS32 memory-access stage and RAM.
// The master drives the request side; the slave answers with ack and read data.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [3:0]        bus_be_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [31:0]       bus_wdata_o;
  logic              bus_ack_i;
  logic [31:0]       bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS32 memory-access stage: turns a decoded load/store into one registered
// req/ack bus transaction, with lane steering, load extension and fault detection.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  input  logic              flush_i,
  mem_access_unit_if.master bus,
  output logic [31:0]       load_data_o,
  output logic              valid_o,
  output logic [4:0]        exc_code_o,
  output logic              pause_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [3:0]      op_p1;
  logic [1:0]      lsb_p1;
  logic [TO_W-1:0] cnt;
  logic            killed;
  logic [4:0]      exc_q;

  logic       is_load, is_store, is_byte, is_half, misaligned;
  logic       op_live, accept, mis_exc, kill_now, timeout_hit, load_p1;
  logic [3:0] be_le, be_lanes;
  logic [31:0] wdata_lanes;

  // Lane order is mirrored for big-endian, and the lane shift is taken from the far end.
  function automatic logic [31:0] extend_load(input logic [3:0] op, input logic [1:0] lsb,
                                              input logic [31:0] rdata);
    logic [1:0]         lane;
    logic [31:0]        shifted;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [31:0]        res;
    case (op)
      OP_LB, OP_LBU: lane = BIG_ENDIAN ? 2'd3 - lsb : lsb;
      OP_LH, OP_LHU: lane = BIG_ENDIAN ? 2'd2 - lsb : lsb;
      default:       lane = 2'd0;
    endcase
    shifted = rdata >> {lane, 3'b000};
    sb = shifted[7:0];
    sh = shifted[15:0];
    case (op)
      OP_LB:   res = 32'(sb);
      OP_LBU:  res = {24'd0, shifted[7:0]};
      OP_LH:   res = 32'(sh);
      OP_LHU:  res = {16'd0, shifted[15:0]};
      default: res = shifted;
    endcase
    return res;
  endfunction

  always_comb begin
    is_load    = (op_i >= OP_LB) && (op_i <= OP_LW);
    is_store   = (op_i >= OP_SB) && (op_i <= OP_SW);
    is_byte    = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
    is_half    = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
    misaligned = is_half ? addr_i[0] : (!is_byte && (addr_i[1:0] != 2'b00));
    op_live    = !rst && (state == IDLE) && !flush_i && (is_load || is_store);
    accept     = op_live && !misaligned;
    mis_exc    = op_live && misaligned;
    kill_now   = killed || flush_i;
    timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
    load_p1    = (op_p1 >= OP_LB) && (op_p1 <= OP_LW);

    if (is_byte)      be_le = 4'b0001 << addr_i[1:0];
    else if (is_half) be_le = 4'b0011 << addr_i[1:0];
    else              be_le = 4'b1111;
    be_lanes = BIG_ENDIAN ? {be_le[0], be_le[1], be_le[2], be_le[3]} : be_le;

    if (is_byte)      wdata_lanes = {4{store_data_i[7:0]}};
    else if (is_half) wdata_lanes = {2{store_data_i[15:0]}};
    else              wdata_lanes = store_data_i;
  end

  assign pause_o    = accept || (state == BUSY);
  assign exc_code_o = mis_exc ? (is_load ? 5'd4 : 5'd5) : exc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_be_o    <= 4'd0;
      bus.bus_addr_o  <= '0;
      bus.bus_wdata_o <= 32'd0;
      load_data_o     <= 32'd0;
      valid_o         <= 1'b0;
      exc_q           <= 5'd0;
      cnt             <= '0;
      killed          <= 1'b0;
      op_p1           <= 4'd0;
      lsb_p1          <= 2'd0;
    end else begin
      case (state)
        // Accept stage: capture the request so the bus sees stable registered values.
        IDLE: begin
          valid_o <= 1'b0;
          exc_q   <= 5'd0;
          if (accept) begin
            bus.bus_req_o   <= 1'b1;
            bus.bus_we_o    <= is_store;
            bus.bus_be_o    <= be_lanes;
            bus.bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus.bus_wdata_o <= wdata_lanes;
            op_p1           <= op_i;
            lsb_p1          <= addr_i[1:0];
            cnt             <= '0;
            killed          <= 1'b0;
            state           <= BUSY;
          end
        end
        // Bus stage: a flush cannot withdraw the request, it only suppresses the result.
        BUSY: begin
          if (flush_i) killed <= 1'b1;
          if (bus.bus_ack_i) begin
            bus.bus_req_o <= 1'b0;
            valid_o       <= !kill_now;
            if (!kill_now && load_p1)
              load_data_o <= extend_load(op_p1, lsb_p1, bus.bus_rdata_i);
            state <= DONE;
          end else if (timeout_hit) begin
            bus.bus_req_o <= 1'b0;
            valid_o       <= !kill_now;
            exc_q         <= kill_now ? 5'd0 : 5'd7;
            state         <= DONE;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        // Completion stage: one-cycle result pulse.
        DONE: begin
          valid_o <= 1'b0;
          exc_q   <= 5'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
